lcd_char_responder: RTL and testbench
=====================================

Name: lcd_char_responder

Overview:
- Synthesizable responder for the 4-bit HD44780-style character-LCD bus that the display driver initiates (LCDE/LCDRS/LCDRW/LCDDAT).
- Decodes nibble pairs into instructions and data writes, and maintains a 2x16 DDRAM image plus controller state.
- Used as the on-chip loopback/verification sink for the display path; its DDRAM image lets a bench compare against the packed string the driver was given.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchronizer for e/rs/rw/dat.
- CLEAR_CYCLES, 32, busy duration of the Clear Display instruction; one DDRAM cell is cleared per cycle, and the value must be >= 32.

Ports:
- clk  in  1  system clock; must be faster than the LCD E strobe.
- rst  in  1  asynchronous, active-high reset.
- lcd_e  in  1  enable strobe; bus sampled on its falling edge.
- lcd_rs  in  1  0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read (reads not supported).
- lcd_dat  in  4  data nibble.
- ddram  out  256  character image; line0 col0 at [255:248] ... line0 col15 at [135:128], line1 col0 at [127:120] ... line1 col15 at [7:0].
- addr  out  7  address counter in HD44780 form: {line, 1'b0, col[3:0]} plus bit 6, i.e. 0x00-0x0F and 0x40-0x4F.
- four_bit  out  1  set once the 4-bit interface is established.
- display_on  out  1  D bit from Display Control.
- busy  out  1  high while a clear is in progress.
- byte_valid  out  1  one-cycle strobe when a complete byte is decoded.
- byte_rs  out  1  rs of that byte.
- byte_data  out  8  that byte.
- overrun  out  1  sticky; a byte arrived while busy.
- rd_err  out  1  sticky; a falling E was seen with rw=1.

Behaviour:
- **Reset values** (asynchronous, immediate): ddram all 0x20, AC index 0, addr 0x00, state INIT8, four_bit 0, display_on 0, incr 1, busy 0, byte_valid 0, byte_rs 0, byte_data 0, overrun 0, rd_err 0, clear counter 0.
- **Input sampling**:
  - e, rs, rw and dat each pass through SYNC_STAGES flops.
  - A falling edge of the synced e (prev=1, cur=0) is the sample event, using the synced rs/rw/dat captured in the same cycle.
  - Latency from pin E fall to register update is SYNC_STAGES+1 clk cycles.
- **rw handling**: a sample with rw=1 sets rd_err and is otherwise ignored. No nibble-phase change, no state change.
- **State INIT8** (8-bit mode):
  - Each sample is a complete byte {dat, 4'h0}.
  - rs=0 and dat=0x3: stay in INIT8 and pulse byte_valid.
  - rs=0 and dat=0x2: go to NIB_HI, set four_bit, pulse byte_valid.
  - Any other sample is ignored.
- **State NIB_HI**: latch dat as the high nibble, then go to NIB_LO.
- **State NIB_LO**:
  - Form the byte {hi, dat} and pulse byte_valid with byte_rs/byte_data.
  - Go to NIB_HI.
  - The rs of the low-nibble sample is the byte's rs.
- **Instruction decode** (rs=0), by highest set bit:
  - 0x01 Clear: enter CLEAR.
  - 0x02/0x03 Home: AC=0.
  - 0x04-0x07 Entry: incr=bit1.
  - 0x08-0x0F Display control: display_on=bit2.
  - 0x10-0x1F Shift: ignored.
  - 0x20-0x3F Function set: if bit4=1, return to INIT8 and clear four_bit.
  - 0x40-0x7F CGRAM: ignored.
  - 0x80-0xFF Set DDRAM address:
    - AC index = {a[6], a[3:0]}.
    - Addresses with col>15 or a[5:4]!=0 are accepted, but only a[6] and a[3:0] are used.
- **Data write** (rs=1):
  - ddram[index] = byte.
  - Then index +1 when incr=1, or -1 when incr=0, modulo 32: 31->0 and 0->31. Line 0 col 15 flows into line 1 col 0.
- **CLEAR**:
  - busy=1 for exactly CLEAR_CYCLES cycles, starting the cycle after decode.
  - Cell k=counter is written to 0x20 while counter<32.
  - At the end: AC=0, incr=1, busy=0, return to the prior nibble state.
- **Bytes during busy**:
  - The nibble FSM still advances, so nibble alignment is preserved.
  - byte_valid still pulses, but the byte is not executed and overrun is set.
- **Simultaneous events**: a sample event in the final busy cycle counts as during busy.
- **Reset mid-clear**: all state returns to reset values immediately; a partial clear is irrelevant because reset fills 0x20.

Decomposition:
- Package lcd_pkg holds:
  - state encoding INIT8/NIB_HI/NIB_LO/CLEAR;
  - instruction masks CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP, CMD_FUNC, CMD_DDRAM;
  - CHAR_SPACE=8'h20; LCD_CHARS=32; LINE1_BASE=7'h40.
- Sub-module lcd_bus_sync: SYNC_STAGES synchronizer plus falling-edge detect. It outputs fall, rs_s, rw_s, dat_s.

Test Plan:
- **Init**: E pulses with rs=0 and nibbles 3,3,3,2 -> four_bit=1 after the 4th, byte_valid pulsed 4 times with byte_data 0x30,0x30,0x30,0x20.
- **Write**: after init, rs=1 nibbles 4,1 -> ddram[255:248]=0x41, addr=0x01, byte_valid with byte_rs=1, SYNC_STAGES+1 cycles after the second E fall.
- **Address + wrap**:
  - Instruction 0xCF, then data 0x5A -> ddram[7:0]=0x5A, addr=0x00.
  - Entry 0x04, then data 0x42 -> ddram[255:248]=0x42, addr=0x4F.
- **Clear + overrun**:
  - Fill with "12345678..." then issue 0x01 -> busy high exactly 32 cycles, then ddram all 0x20 and addr=0.
  - A data byte 0x41 sent during busy -> overrun=1 and ddram unchanged.
- **Read attempt**: E pulse with rw=1 mid-byte -> rd_err=1; the following low nibble still completes the correct byte.
- **Reset mid-operation**: assert rst during a clear and between nibbles -> all outputs at reset values immediately; after re-init, a full 32-char write reproduces the packed string exactly.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style 4-bit LCD bus responder.
package lcd_pkg;

  typedef enum logic [1:0] {
    StInit8,
    StNibHi,
    StNibLo,
    StClear
  } lcd_state_e;

  // Instruction class masks; the class is chosen by the highest set bit.
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [7:0]  CHAR_SPACE = 8'h20;
  localparam int unsigned LCD_CHARS  = 32;
  localparam logic [6:0]  LINE1_BASE = 7'h40;

  function automatic logic [6:0] ac_to_addr(input logic [4:0] idx);
    return (idx[4] ? LINE1_BASE : 7'h00) | {3'b000, idx[3:0]};
  endfunction

  function automatic logic [4:0] addr_to_idx(input logic [7:0] a);
    return {a[6], a[3:0]};
  endfunction

endpackage

// File: rtl/lcd_char_responder_bus_sync.sv
// Multi-flop synchronizer for the LCD pins plus falling-edge detect on E.
module lcd_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_dat,
  output logic       fall,
  output logic       rs_s,
  output logic       rw_s,
  output logic [3:0] dat_s
);

  // All pins travel through the same depth so rs/rw/dat line up with the E edge.
  logic [6:0] sync_d [SYNC_STAGES];
  logic [6:0] sync_q [SYNC_STAGES];
  logic       e_prev_d, e_prev_q;

  always_comb begin
    sync_d[0] = {lcd_e, lcd_rs, lcd_rw, lcd_dat};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    e_prev_d = sync_q[SYNC_STAGES-1][6];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      e_prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      e_prev_q <= e_prev_d;
    end
  end

  assign fall  = e_prev_q & ~sync_q[SYNC_STAGES-1][6];
  assign rs_s  = sync_q[SYNC_STAGES-1][5];
  assign rw_s  = sync_q[SYNC_STAGES-1][4];
  assign dat_s = sync_q[SYNC_STAGES-1][3:0];

endmodule

// File: rtl/lcd_char_responder.sv
// HD44780-style 4-bit bus responder: decodes nibble pairs, keeps a 2x16 DDRAM image.
module lcd_char_responder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CLEAR_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lcd_e,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic [3:0]   lcd_dat,
  output logic [255:0] ddram,
  output logic [6:0]   addr,
  output logic         four_bit,
  output logic         display_on,
  output logic         busy,
  output logic         byte_valid,
  output logic         byte_rs,
  output logic [7:0]   byte_data,
  output logic         overrun,
  output logic         rd_err
);
  import lcd_pkg::*;

  localparam int unsigned CntW = $clog2(CLEAR_CYCLES) + 1;

  logic       fall, rs_s, rw_s;
  logic [3:0] dat_s;

  lcd_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_dat(lcd_dat),
    .fall   (fall),
    .rs_s   (rs_s),
    .rw_s   (rw_s),
    .dat_s  (dat_s)
  );

  lcd_state_e      state_d, state_q;
  lcd_state_e      ret_d, ret_q;
  logic [7:0]      mem_d [LCD_CHARS];
  logic [7:0]      mem_q [LCD_CHARS];
  logic [4:0]      idx_d, idx_q;
  logic            incr_d, incr_q;
  logic            four_bit_d, four_bit_q;
  logic            disp_d, disp_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic [3:0]      hi_d, hi_q;
  logic            bv_d, bv_q;
  logic            brs_d, brs_q;
  logic [7:0]      bdat_d, bdat_q;
  logic            ovr_d, ovr_q;
  logic            rderr_d, rderr_q;

  lcd_state_e phase, phase_nx;
  logic       is_busy, got_byte, got_full, start_clear;
  logic [7:0] byte_v;
  logic       byte_rs_v;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    mem_d       = mem_q;
    idx_d       = idx_q;
    incr_d      = incr_q;
    four_bit_d  = four_bit_q;
    disp_d      = disp_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    bv_d        = 1'b0;
    brs_d       = brs_q;
    bdat_d      = bdat_q;
    ovr_d       = ovr_q;
    rderr_d     = rderr_q;
    got_byte    = 1'b0;
    got_full    = 1'b0;
    start_clear = 1'b0;
    byte_v      = 8'h00;
    byte_rs_v   = 1'b0;

    // While clearing, the nibble phase lives in ret_q so alignment survives the clear.
    is_busy  = (state_q == StClear);
    phase    = is_busy ? ret_q : state_q;
    phase_nx = phase;

    if (fall) begin
      if (rw_s) begin
        rderr_d = 1'b1;
      end else begin
        unique case (phase)
          StInit8: begin
            if (!rs_s && (dat_s == 4'h3 || dat_s == 4'h2)) begin
              got_byte = 1'b1;
              byte_v   = {dat_s, 4'h0};
              if (dat_s == 4'h2) begin
                phase_nx   = StNibHi;
                four_bit_d = 1'b1;
              end
            end
          end
          StNibHi: begin
            hi_d     = dat_s;
            phase_nx = StNibLo;
          end
          StNibLo: begin
            got_byte  = 1'b1;
            got_full  = 1'b1;
            byte_v    = {hi_q, dat_s};
            byte_rs_v = rs_s;
            phase_nx  = StNibHi;
          end
          default: ;
        endcase
      end
    end

    if (got_byte) begin
      bv_d   = 1'b1;
      brs_d  = byte_rs_v;
      bdat_d = byte_v;
      if (is_busy) begin
        ovr_d = 1'b1;
      end
    end

    if (got_full && !is_busy) begin
      if (byte_rs_v) begin
        mem_d[idx_q] = byte_v;
        idx_d        = incr_q ? idx_q + 5'd1 : idx_q - 5'd1;
      end else if ((byte_v & CMD_DDRAM) != '0) begin
        idx_d = addr_to_idx(byte_v);
      end else if ((byte_v & CMD_CGRAM) != '0) begin
        idx_d = idx_q;
      end else if ((byte_v & CMD_FUNC) != '0) begin
        if (byte_v[4]) begin
          phase_nx   = StInit8;
          four_bit_d = 1'b0;
        end
      end else if ((byte_v & CMD_SHIFT) != '0) begin
        idx_d = idx_q;
      end else if ((byte_v & CMD_DISP) != '0) begin
        disp_d = byte_v[2];
      end else if ((byte_v & CMD_ENTRY) != '0) begin
        incr_d = byte_v[1];
      end else if ((byte_v & CMD_HOME) != '0) begin
        idx_d = 5'd0;
      end else if ((byte_v & CMD_CLEAR) != '0) begin
        start_clear = 1'b1;
      end
    end

    if (is_busy) begin
      ret_d = phase_nx;
      if (cnt_q < CntW'(LCD_CHARS)) begin
        mem_d[cnt_q[4:0]] = CHAR_SPACE;
      end
      if (cnt_q == CntW'(CLEAR_CYCLES - 1)) begin
        state_d = phase_nx;
        idx_d   = 5'd0;
        incr_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (start_clear) begin
      state_d = StClear;
      ret_d   = phase_nx;
      cnt_d   = '0;
    end else begin
      state_d = phase_nx;
      ret_d   = phase_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StInit8;
      ret_q      <= StInit8;
      for (int i = 0; i < LCD_CHARS; i++) begin
        mem_q[i] <= CHAR_SPACE;
      end
      idx_q      <= 5'd0;
      incr_q     <= 1'b1;
      four_bit_q <= 1'b0;
      disp_q     <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= 4'h0;
      bv_q       <= 1'b0;
      brs_q      <= 1'b0;
      bdat_q     <= 8'h00;
      ovr_q      <= 1'b0;
      rderr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      mem_q      <= mem_d;
      idx_q      <= idx_d;
      incr_q     <= incr_d;
      four_bit_q <= four_bit_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      bv_q       <= bv_d;
      brs_q      <= brs_d;
      bdat_q     <= bdat_d;
      ovr_q      <= ovr_d;
      rderr_q    <= rderr_d;
    end
  end

  for (genvar g = 0; g < LCD_CHARS; g++) begin : g_ddram
    assign ddram[8*(LCD_CHARS-1-g) +: 8] = mem_q[g];
  end

  assign addr       = ac_to_addr(idx_q);
  assign four_bit   = four_bit_q;
  assign display_on = disp_q;
  assign busy       = (state_q == StClear);
  assign byte_valid = bv_q;
  assign byte_rs    = brs_q;
  assign byte_data  = bdat_q;
  assign overrun    = ovr_q;
  assign rd_err     = rderr_q;

endmodule

// File: tb/tb_lcd_char_responder.sv
// Directed bench for lcd_char_responder: drives E-strobed nibbles and checks the image.
module tb_lcd_char_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         lcd_e, lcd_rs, lcd_rw;
  logic [3:0]   lcd_dat;
  logic [255:0] ddram;
  logic [6:0]   addr;
  logic         four_bit, display_on, busy, byte_valid, byte_rs, overrun, rd_err;
  logic [7:0]   byte_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] bv_q[$];

  localparam logic [255:0] ALL_SPACE = {32{8'h20}};

  lcd_char_responder #(
    .SYNC_STAGES (2),
    .CLEAR_CYCLES(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_dat   (lcd_dat),
    .ddram     (ddram),
    .addr      (addr),
    .four_bit  (four_bit),
    .display_on(display_on),
    .busy      (busy),
    .byte_valid(byte_valid),
    .byte_rs   (byte_rs),
    .byte_data (byte_data),
    .overrun   (overrun),
    .rd_err    (rd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) bv_q.push_back({byte_rs, byte_data});
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic e_pulse(input logic rs, input logic rw, input logic [3:0] d, input int settle);
    @(negedge clk);
    lcd_rs  = rs;
    lcd_rw  = rw;
    lcd_dat = d;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic nib(input logic rs, input logic [3:0] d);
    e_pulse(rs, 1'b0, d, 6);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    nib(rs, b[7:4]);
    nib(rs, b[3:0]);
  endtask

  task automatic init_seq();
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] fill, msg;
    int base, nbusy;

    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_dat = 4'h0;
    #1;
    check("rst_ddram", ddram, ALL_SPACE);
    check("rst_addr", addr, 7'h00);
    check("rst_four_bit", four_bit, 1'b0);
    check("rst_display_on", display_on, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_byte", {byte_rs, byte_data}, 9'h000);
    check("rst_flags", {overrun, rd_err}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Init: 3,3,3,2
    base = bv_q.size();
    nib(1'b0, 4'h3);
    check("init_four_bit_early", four_bit, 1'b0);
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h3);
    nib(1'b0, 4'h2);
    check("init_four_bit", four_bit, 1'b1);
    check("init_bv_count", bv_q.size() - base, 4);
    check("init_b0", bv_q[base], 9'h030);
    check("init_b1", bv_q[base+1], 9'h030);
    check("init_b2", bv_q[base+2], 9'h030);
    check("init_b3", bv_q[base+3], 9'h020);

    send_byte(1'b0, 8'h0C);
    check("display_on", display_on, 1'b1);
    send_byte(1'b0, 8'h06);

    // Write 'A' with latency check after the second E fall
    nib(1'b1, 4'h4);
    e_pulse(1'b1, 1'b0, 4'h1, 0);
    repeat (2) @(negedge clk);
    check("write_bv_early", byte_valid, 1'b0);
    @(negedge clk);
    check("write_bv", byte_valid, 1'b1);
    check("write_byte", {byte_rs, byte_data}, 9'h141);
    repeat (4) @(negedge clk);
    check("write_cell0", ddram[255:248], 8'h41);
    check("write_addr", addr, 7'h01);

    // Address set and wrap in both directions
    send_byte(1'b0, 8'hCF);
    check("setaddr_4f", addr, 7'h4F);
    send_byte(1'b1, 8'h5A);
    check("wrap_cell31", ddram[7:0], 8'h5A);
    check("wrap_addr_up", addr, 7'h00);
    send_byte(1'b0, 8'h04);
    send_byte(1'b1, 8'h42);
    check("dec_cell0", ddram[255:248], 8'h42);
    check("wrap_addr_down", addr, 7'h4F);

    // Read attempt between nibbles of 0x80
    send_byte(1'b0, 8'h06);
    nib(1'b0, 4'h8);
    e_pulse(1'b0, 1'b1, 4'h5, 6);
    check("rd_err", rd_err, 1'b1);
    nib(1'b0, 4'h0);
    check("rd_byte", bv_q[bv_q.size()-1], 9'h080);
    check("rd_addr", addr, 7'h00);

    // Fill all 32 cells
    fill = "123456789ABCDEFGHIJKLMNOPQRSTUVW";
    for (int i = 0; i < 32; i++) send_byte(1'b1, fill[255-8*i -: 8]);
    check("fill_ddram", ddram, fill);
    check("fill_addr", addr, 7'h00);

    // Clear (with decrement mode set beforehand)
    send_byte(1'b0, 8'h04);
    nib(1'b0, 4'h0);
    e_pulse(1'b0, 1'b0, 4'h1, 0);
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    check("clear_busy_cycles", nbusy, 32);
    check("clear_ddram", ddram, ALL_SPACE);
    check("clear_addr", addr, 7'h00);
    check("clear_no_overrun", overrun, 1'b0);
    send_byte(1'b1, 8'h31);
    check("clear_incr_cell", ddram[255:248], 8'h31);
    check("clear_incr_addr", addr, 7'h01);

    // Clear with a data byte during busy
    nib(1'b0, 4'h0);
    e_pulse(1'b0, 1'b0, 4'h1, 0);
    send_byte(1'b1, 8'h41);
    check("ovr_busy_still", busy, 1'b1);
    repeat (30) @(negedge clk);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_ddram", ddram, ALL_SPACE);
    check("ovr_byte", bv_q[bv_q.size()-1], 9'h141);
    check("ovr_addr", addr, 7'h00);
    send_byte(1'b1, 8'h5A);
    check("align_cell0", ddram[255:248], 8'h5A);
    check("align_addr", addr, 7'h01);

    // Reset mid-clear
    nib(1'b0, 4'h0);
    e_pulse(1'b0, 1'b0, 4'h1, 10);
    rst = 1'b1;
    #1;
    check("rstclr_busy", busy, 1'b0);
    check("rstclr_ddram", ddram, ALL_SPACE);
    check("rstclr_addr", addr, 7'h00);
    check("rstclr_ctl", {four_bit, display_on}, 2'b00);
    check("rstclr_flags", {overrun, rd_err}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Reset between nibbles
    init_seq();
    nib(1'b1, 4'h4);
    rst = 1'b1;
    #1;
    check("rstnib_byte", {byte_rs, byte_data}, 9'h000);
    check("rstnib_four_bit", four_bit, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    init_seq();
    check("reinit_four_bit", four_bit, 1'b1);
    msg = "Hello, LCD loop!Second line 0123";
    for (int i = 0; i < 32; i++) send_byte(1'b1, msg[255-8*i -: 8]);
    check("msg_ddram", ddram, msg);
    check("msg_addr", addr, 7'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
